// File: rtl/lpm_table_ctrl_if.sv
// lpm_table_ctrl_if: register-side command and response channels of the LPM
// route table controller.
//
// Handshake: both channels are valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, the
// sender holds valid and all payload fields stable until that transfer edge.
// Ready may be raised or lowered freely and never depends on a later cycle.
interface lpm_table_ctrl_if #(
  parameter int NUM_QUEUES     = 8,
  parameter int LUT_DEPTH_BITS = 5
);
  // Command channel, from the register block to the controller.
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [LUT_DEPTH_BITS-1:0] cmd_addr;
  logic [31:0]               cmd_ip;
  logic [31:0]               cmd_mask;
  logic [31:0]               cmd_next_hop_ip;
  logic [NUM_QUEUES-1:0]     cmd_oq;

  // Response channel, from the controller to the register block.
  logic                      resp_valid;
  logic                      resp_ready;
  logic [1:0]                resp_status;
  logic [31:0]               resp_ip;
  logic [31:0]               resp_mask;
  logic [31:0]               resp_next_hop_ip;
  logic [NUM_QUEUES-1:0]     resp_oq;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_ip, cmd_mask, cmd_next_hop_ip, cmd_oq,
    output resp_ready,
    input  cmd_ready,
    input  resp_valid, resp_status, resp_ip, resp_mask, resp_next_hop_ip, resp_oq
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_ip, cmd_mask, cmd_next_hop_ip, cmd_oq,
    input  resp_ready,
    output cmd_ready,
    output resp_valid, resp_status, resp_ip, resp_mask, resp_next_hop_ip, resp_oq
  );
endinterface

// File: rtl/lpm_table_ctrl.sv
// lpm_table_ctrl: register-side initiator for the LPM route table.
// Accepts read / write / clear-all commands, drives the table's level-held
// request ports until the pulsed ack, and returns status plus read data.
// Optional feature macro: LPM_TBL_CTRL_TIMEOUT_EN adds an ack-wait timeout of
// TIMEOUT_CYCLES cycles; without it the controller waits for ack forever.
// State is visible on dbg_state (0 IDLE, 1 RD_WAIT, 2 WR_WAIT, 3 CLR_WAIT, 4 RESP).
module lpm_table_ctrl #(
  parameter int NUM_QUEUES     = 8,
  parameter int LUT_DEPTH      = 32,
  parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  lpm_table_ctrl_if.slave           bus,
  output logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
  output logic                      lpm_rd_req,
  input  logic [31:0]               lpm_rd_ip,
  input  logic [31:0]               lpm_rd_mask,
  input  logic [31:0]               lpm_rd_next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_rd_oq,
  input  logic                      lpm_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
  output logic                      lpm_wr_req,
  output logic [31:0]               lpm_wr_ip,
  output logic [31:0]               lpm_wr_mask,
  output logic [31:0]               lpm_wr_next_hop_ip,
  output logic [NUM_QUEUES-1:0]     lpm_wr_oq,
  input  logic                      lpm_wr_ack,
  output logic [2:0]                dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_CLR_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_BAD_ADDR = 2'b10;
  localparam logic [1:0] ST_BAD_OP   = 2'b11;

  localparam logic [LUT_DEPTH_BITS-1:0] LAST_ADDR = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

  logic [2:0]            state;
  logic                  cmd_ready_q;
  logic                  resp_valid_q;
  logic [1:0]            resp_status_q;
  logic [31:0]           resp_ip_q;
  logic [31:0]           resp_mask_q;
  logic [31:0]           resp_next_hop_ip_q;
  logic [NUM_QUEUES-1:0] resp_oq_q;

  logic cmd_fire;
  logic addr_bad;
  logic waiting;
  logic cur_ack;
  logic to_hit;

  assign cmd_fire = (state == S_IDLE) && bus.cmd_valid && cmd_ready_q;
  // Address range only matters for single-entry ops; widened so a
  // non-power-of-two depth compares correctly.
  assign addr_bad = ((bus.cmd_op == OP_RD) || (bus.cmd_op == OP_WR)) &&
                    (32'(bus.cmd_addr) >= 32'(LUT_DEPTH));
  assign waiting  = (state == S_RD_WAIT) || (state == S_WR_WAIT) || (state == S_CLR_WAIT);
  assign cur_ack  = (state == S_RD_WAIT) ? lpm_rd_ack : lpm_wr_ack;

`ifdef LPM_TBL_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;

  // Wait counter: zero whenever a request is (re)issued, counts unacked cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                to_cnt <= '0;
    else if (waiting && !cur_ack) to_cnt <= to_cnt + 1'b1;
    else                        to_cnt <= '0;
  end

  assign to_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No ack timeout in this build; the wait states only leave on ack.
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Command FSM: decode on accept, hold the table request until ack, respond.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      cmd_ready_q        <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_status_q      <= ST_OK;
      resp_ip_q          <= '0;
      resp_mask_q        <= '0;
      resp_next_hop_ip_q <= '0;
      resp_oq_q          <= '0;
      lpm_rd_addr        <= '0;
      lpm_rd_req         <= 1'b0;
      lpm_wr_addr        <= '0;
      lpm_wr_req         <= 1'b0;
      lpm_wr_ip          <= '0;
      lpm_wr_mask        <= '0;
      lpm_wr_next_hop_ip <= '0;
      lpm_wr_oq          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q        <= 1'b0;
            resp_status_q      <= ST_OK;
            resp_ip_q          <= '0;
            resp_mask_q        <= '0;
            resp_next_hop_ip_q <= '0;
            resp_oq_q          <= '0;
            if (bus.cmd_op == OP_RSVD) begin
              resp_status_q <= ST_BAD_OP;
              resp_valid_q  <= 1'b1;
              state         <= S_RESP;
            end else if (addr_bad) begin
              resp_status_q <= ST_BAD_ADDR;
              resp_valid_q  <= 1'b1;
              state         <= S_RESP;
            end else if (bus.cmd_op == OP_RD) begin
              lpm_rd_addr <= bus.cmd_addr;
              lpm_rd_req  <= 1'b1;
              state       <= S_RD_WAIT;
            end else if (bus.cmd_op == OP_WR) begin
              // Host bits are stripped so the table only ever holds canonical prefixes.
              lpm_wr_addr        <= bus.cmd_addr;
              lpm_wr_ip          <= bus.cmd_ip & bus.cmd_mask;
              lpm_wr_mask        <= bus.cmd_mask;
              lpm_wr_next_hop_ip <= bus.cmd_next_hop_ip;
              lpm_wr_oq          <= bus.cmd_oq;
              lpm_wr_req         <= 1'b1;
              state              <= S_WR_WAIT;
            end else begin
              lpm_wr_addr        <= '0;
              lpm_wr_ip          <= '0;
              lpm_wr_mask        <= 32'hFFFF_FFFF;
              lpm_wr_next_hop_ip <= '0;
              lpm_wr_oq          <= '0;
              lpm_wr_req         <= 1'b1;
              state              <= S_CLR_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (lpm_rd_ack) begin
            lpm_rd_req         <= 1'b0;
            resp_ip_q          <= lpm_rd_ip;
            resp_mask_q        <= lpm_rd_mask;
            resp_next_hop_ip_q <= lpm_rd_next_hop_ip;
            resp_oq_q          <= lpm_rd_oq;
            resp_status_q      <= ST_OK;
            resp_valid_q       <= 1'b1;
            state              <= S_RESP;
          end else if (to_hit) begin
            lpm_rd_req    <= 1'b0;
            resp_status_q <= ST_TIMEOUT;
            resp_valid_q  <= 1'b1;
            state         <= S_RESP;
          end
        end
        S_WR_WAIT, S_CLR_WAIT: begin
          if (lpm_wr_ack) begin
            // Clear-all keeps the request high and just steps the address.
            if ((state == S_CLR_WAIT) && (lpm_wr_addr != LAST_ADDR)) begin
              lpm_wr_addr <= lpm_wr_addr + 1'b1;
            end else begin
              lpm_wr_req    <= 1'b0;
              resp_status_q <= ST_OK;
              resp_valid_q  <= 1'b1;
              state         <= S_RESP;
            end
          end else if (to_hit) begin
            lpm_wr_req    <= 1'b0;
            resp_status_q <= ST_TIMEOUT;
            resp_valid_q  <= 1'b1;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_status      = resp_status_q;
  assign bus.resp_ip          = resp_ip_q;
  assign bus.resp_mask        = resp_mask_q;
  assign bus.resp_next_hop_ip = resp_next_hop_ip_q;
  assign bus.resp_oq          = resp_oq_q;
  assign dbg_state            = state;

endmodule

// File: tb/tb_lpm_table_ctrl.sv
// tb_lpm_table_ctrl: directed bench for lpm_table_ctrl. Main instance uses
// LUT_DEPTH 32 with a latency-programmable table responder; a second instance
// with LUT_DEPTH 40 covers the out-of-range address path.
module tb_lpm_table_ctrl;

  localparam int W = 5 + 32 * 3 + 8;  // write record: addr, ip, mask, hop, oq

  logic clk;
  logic resetn;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (LUT_DEPTH 32) ----------------
  lpm_table_ctrl_if #(.NUM_QUEUES(8), .LUT_DEPTH_BITS(5)) bus ();

  logic [4:0]  lpm_rd_addr, lpm_wr_addr;
  logic        lpm_rd_req, lpm_wr_req, lpm_rd_ack, lpm_wr_ack;
  logic [31:0] lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip;
  logic [7:0]  lpm_rd_oq, lpm_wr_oq;
  logic [31:0] lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip;
  logic [2:0]  dbg_state;

  lpm_table_ctrl #(.NUM_QUEUES(8), .LUT_DEPTH(32), .LUT_DEPTH_BITS(5), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .lpm_rd_addr(lpm_rd_addr), .lpm_rd_req(lpm_rd_req),
    .lpm_rd_ip(lpm_rd_ip), .lpm_rd_mask(lpm_rd_mask),
    .lpm_rd_next_hop_ip(lpm_rd_next_hop_ip), .lpm_rd_oq(lpm_rd_oq), .lpm_rd_ack(lpm_rd_ack),
    .lpm_wr_addr(lpm_wr_addr), .lpm_wr_req(lpm_wr_req),
    .lpm_wr_ip(lpm_wr_ip), .lpm_wr_mask(lpm_wr_mask),
    .lpm_wr_next_hop_ip(lpm_wr_next_hop_ip), .lpm_wr_oq(lpm_wr_oq), .lpm_wr_ack(lpm_wr_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (LUT_DEPTH 40), table side idle ----------------
  lpm_table_ctrl_if #(.NUM_QUEUES(8), .LUT_DEPTH_BITS(6)) bus40 ();

  logic [5:0]  d40_rd_addr, d40_wr_addr;
  logic        d40_rd_req, d40_wr_req;
  logic [31:0] d40_wr_ip, d40_wr_mask, d40_wr_hop;
  logic [7:0]  d40_wr_oq;
  logic [2:0]  d40_state;
  logic [31:0] zero32;
  logic [7:0]  zero8;
  logic        zero1;

  assign zero32 = '0;
  assign zero8  = '0;
  assign zero1  = 1'b0;

  lpm_table_ctrl #(.NUM_QUEUES(8), .LUT_DEPTH(40), .LUT_DEPTH_BITS(6), .TIMEOUT_CYCLES(64)) dut40 (
    .clk(clk), .resetn(resetn), .bus(bus40),
    .lpm_rd_addr(d40_rd_addr), .lpm_rd_req(d40_rd_req),
    .lpm_rd_ip(zero32), .lpm_rd_mask(zero32),
    .lpm_rd_next_hop_ip(zero32), .lpm_rd_oq(zero8), .lpm_rd_ack(zero1),
    .lpm_wr_addr(d40_wr_addr), .lpm_wr_req(d40_wr_req),
    .lpm_wr_ip(d40_wr_ip), .lpm_wr_mask(d40_wr_mask),
    .lpm_wr_next_hop_ip(d40_wr_hop), .lpm_wr_oq(d40_wr_oq), .lpm_wr_ack(zero1),
    .dbg_state(d40_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- table responder ----------------
  // rd_lat / wr_lat = number of cycles the request is high, ack cycle included.
  int   rd_lat = 2, wr_lat = 1;
  int   rd_cnt = 0, wr_cnt = 0;
  logic ack_en = 1'b1;
  logic rd_ack_r = 1'b0, wr_ack_r = 1'b0;
  logic inj_rd_ack = 1'b0, inj_wr_ack = 1'b0;
  logic [31:0] rd_ip_v = '0, rd_mask_v = '0, rd_hop_v = '0;
  logic [7:0]  rd_oq_v = '0;

  assign lpm_rd_ack         = rd_ack_r | inj_rd_ack;
  assign lpm_wr_ack         = wr_ack_r | inj_wr_ack;
  assign lpm_rd_ip          = rd_ip_v;
  assign lpm_rd_mask        = rd_mask_v;
  assign lpm_rd_next_hop_ip = rd_hop_v;
  assign lpm_rd_oq          = rd_oq_v;

  always @(negedge clk) begin
    if (lpm_rd_req && ack_en) begin
      rd_cnt = rd_cnt + 1;
      if (rd_cnt == rd_lat) begin rd_ack_r = 1'b1; rd_cnt = 0; end
      else rd_ack_r = 1'b0;
    end else begin
      rd_ack_r = 1'b0; rd_cnt = 0;
    end
    if (lpm_wr_req && ack_en) begin
      wr_cnt = wr_cnt + 1;
      if (wr_cnt == wr_lat) begin wr_ack_r = 1'b1; wr_cnt = 0; end
      else wr_ack_r = 1'b0;
    end else begin
      wr_ack_r = 1'b0; wr_cnt = 0;
    end
  end

  // ---------------- monitor: acked writes vs expected queue ----------------
  int rd_req_cyc = 0, wr_req_cyc = 0, d40_req_cyc = 0;
  always @(posedge clk) begin
    if (lpm_rd_req) rd_req_cyc++;
    if (lpm_wr_req) wr_req_cyc++;
    if (d40_rd_req || d40_wr_req) d40_req_cyc++;
    if (resetn && lpm_wr_req && lpm_wr_ack) begin
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0)
        check("wr_rec", {lpm_wr_addr, lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq},
              exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] ip,
                        input logic [31:0] mask, input logic [31:0] hop, input logic [7:0] oq);
    int n;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_ip = ip; bus.cmd_mask = mask;
    bus.cmd_next_hop_ip = hop; bus.cmd_oq = oq; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_seen", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Counts edges from the call point until resp_valid is seen (0 if already high).
  task automatic wait_resp(input int limit, output int cyc);
    cyc = 0;
    while (!bus.resp_valid && cyc < limit) begin @(posedge clk); #1; cyc++; end
    check("resp_valid_seen", bus.resp_valid, 1'b1);
  endtask

  task automatic ack_resp();
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
  endtask

  task automatic cmd40(input logic [1:0] op, input logic [5:0] addr,
                       output logic [1:0] st, output int lat);
    int n;
    @(negedge clk);
    bus40.cmd_op = op; bus40.cmd_addr = addr; bus40.cmd_valid = 1'b1;
    n = 0;
    while (!bus40.cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("d40_cmd_ready", bus40.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus40.cmd_valid = 1'b0;
    lat = 0;
    while (!bus40.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    st = bus40.resp_status;
    @(negedge clk); bus40.resp_ready = 1'b1;
    @(posedge clk); #1; bus40.resp_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, cyc, base_rd, base_wr, lat;
    logic [1:0] st;

    resetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_ip = '0;
    bus.cmd_mask = '0; bus.cmd_next_hop_ip = '0; bus.cmd_oq = '0; bus.resp_ready = 1'b0;
    bus40.cmd_valid = 1'b0; bus40.cmd_op = '0; bus40.cmd_addr = '0; bus40.cmd_ip = '0;
    bus40.cmd_mask = '0; bus40.cmd_next_hop_ip = '0; bus40.cmd_oq = '0; bus40.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_reqs", {lpm_rd_req, lpm_wr_req}, 2'b00);
    check("rst_status", bus.resp_status, 2'b00);
    check("rst_wr_mask", lpm_wr_mask, 32'h0);
    check("rst_state", dbg_state, 3'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("rel_cmd_ready", bus.cmd_ready, 1'b1);

    // Write addr 3: 10.1.2.77/24 -> stored as 10.1.2.0, ack after 16 cycles
    wr_lat = 16;
    exp_q.push_back({5'd3, 32'h0A01_0200, 32'hFFFF_FF00, 32'h0A00_0001, 8'h04});
    do_cmd(2'b01, 5'd3, 32'h0A01_024D, 32'hFFFF_FF00, 32'h0A00_0001, 8'h04);
    check("wr_req_rise", lpm_wr_req, 1'b1);
    check("wr_ip_canon", lpm_wr_ip, 32'h0A01_0200);
    check("wr_addr", lpm_wr_addr, 5'd3);
    n = 0;
    while (lpm_wr_req && n < 300) begin @(negedge clk); if (lpm_wr_req) n++; end
    check("wr_req_cycles", n, 16);
    wait_resp(50, cyc);
    check("wr_status", bus.resp_status, 2'b00);
    check("wr_resp_ip_zero", bus.resp_ip, 32'h0);
    ack_resp();

    // Read addr 3, responder acks one cycle after seeing the request
    rd_lat = 2;
    rd_ip_v = 32'h0A01_0200; rd_mask_v = 32'hFFFF_FF00; rd_hop_v = 32'h0A00_0001; rd_oq_v = 8'h04;
    do_cmd(2'b00, 5'd3, 32'h0, 32'h0, 32'h0, 8'h0);
    check("rd_req_rise", lpm_rd_req, 1'b1);
    check("rd_addr", lpm_rd_addr, 5'd3);
    wait_resp(50, cyc);
    check("rd_latency", cyc, 2);
    check("rd_req_fall", lpm_rd_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rd_hold_valid", bus.resp_valid, 1'b1);
      check("rd_hold_ip", bus.resp_ip, 32'h0A01_0200);
    end
    check("rd_status", bus.resp_status, 2'b00);
    check("rd_mask", bus.resp_mask, 32'hFFFF_FF00);
    check("rd_hop", bus.resp_next_hop_ip, 32'h0A00_0001);
    check("rd_oq", bus.resp_oq, 8'h04);
    ack_resp();

    // Clear-all: 32 back-to-back entry writes, a single OK response
    wr_lat = 1;
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 32'h0, 32'hFFFF_FFFF, 32'h0, 8'h0});
    do_cmd(2'b10, 5'd9, 32'h1234_5678, 32'h0, 32'h0, 8'h0);
    n = 0;
    while (lpm_wr_req && n < 300) begin @(negedge clk); if (lpm_wr_req) n++; end
    check("clr_req_cycles", n, 32);
    wait_resp(50, cyc);
    check("clr_status", bus.resp_status, 2'b00);
    check("clr_resp_ip_zero", bus.resp_ip, 32'h0);
    check("clr_all_written", exp_q.size(), 0);
    ack_resp();
    @(negedge clk);
    check("clr_single_resp", bus.resp_valid, 1'b0);
    check("clr_back_idle", dbg_state, 3'd0);

    // Reset while clear-all is on entry 7: entries 0..6 land, then all stops
    for (int i = 0; i < 7; i++) exp_q.push_back({5'(i), 32'h0, 32'hFFFF_FFFF, 32'h0, 8'h0});
    do_cmd(2'b10, 5'd0, 32'h0, 32'h0, 32'h0, 8'h0);
    n = 0;
    while (lpm_wr_addr != 5'd7 && n < 100) begin @(negedge clk); n++; end
    check("mid_clr_addr7", lpm_wr_addr, 5'd7);
    resetn = 1'b0;
    #1;
    check("mid_rst_wr_req", lpm_wr_req, 1'b0);
    check("mid_rst_wr_addr", lpm_wr_addr, 5'd0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("mid_rst_state", dbg_state, 3'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_cmd_ready", bus.cmd_ready, 1'b1);
    check("mid_rel_no_resp", bus.resp_valid, 1'b0);
    check("mid_entries_0_6", exp_q.size(), 0);

    // Stray acks in IDLE are ignored
    base_wr = wr_req_cyc;
    @(negedge clk); inj_rd_ack = 1'b1; inj_wr_ack = 1'b1;
    @(negedge clk); inj_rd_ack = 1'b0; inj_wr_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_state", dbg_state, 3'd0);
    check("idle_ack_resp", bus.resp_valid, 1'b0);
    check("idle_ack_no_req", wr_req_cyc - base_wr, 0);

    // Reserved op on the main instance
    base_rd = rd_req_cyc; base_wr = wr_req_cyc;
    do_cmd(2'b11, 5'd3, 32'h0, 32'h0, 32'h0, 8'h0);
    wait_resp(20, cyc);
    check("badop_latency", cyc, 0);
    check("badop_status", bus.resp_status, 2'b11);
    ack_resp();
    check("badop_no_req", (rd_req_cyc - base_rd) + (wr_req_cyc - base_wr), 0);

    // LUT_DEPTH 40 instance: addr 40 is out of range, then reserved op
    cmd40(2'b00, 6'd40, st, lat);
    check("badaddr_status", st, 2'b10);
    check("badaddr_latency", lat, 0);
    cmd40(2'b01, 6'd63, st, lat);
    check("badaddr_wr_status", st, 2'b10);
    cmd40(2'b11, 6'd0, st, lat);
    check("d40_badop_status", st, 2'b11);
    check("d40_no_req", d40_req_cyc, 0);

`ifdef LPM_TBL_CTRL_TIMEOUT_EN
    // No ack: TIMEOUT after 64 wait cycles, late ack ignored, next read fine
    ack_en = 1'b0;
    do_cmd(2'b00, 5'd5, 32'h0, 32'h0, 32'h0, 8'h0);
    wait_resp(200, cyc);
    check("to_latency", cyc, 64);
    check("to_status", bus.resp_status, 2'b01);
    check("to_req_dropped", lpm_rd_req, 1'b0);
    check("to_resp_ip_zero", bus.resp_ip, 32'h0);
    @(negedge clk); inj_rd_ack = 1'b1;
    @(negedge clk); inj_rd_ack = 1'b0;
    check("to_late_ack_valid", bus.resp_valid, 1'b1);
    check("to_late_ack_status", bus.resp_status, 2'b01);
    ack_resp();
    ack_en = 1'b1; rd_lat = 2;
    rd_ip_v = 32'hC0A8_0100; rd_mask_v = 32'hFFFF_FF00; rd_hop_v = 32'hC0A8_0001; rd_oq_v = 8'h10;
    do_cmd(2'b00, 5'd5, 32'h0, 32'h0, 32'h0, 8'h0);
    wait_resp(50, cyc);
    check("to_next_latency", cyc, 2);
    check("to_next_status", bus.resp_status, 2'b00);
    check("to_next_ip", bus.resp_ip, 32'hC0A8_0100);
    ack_resp();
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
